// File: rtl/j68_muldiv_seq_if.sv
// j68_muldiv_seq_if: start/done handshake, operands, result and the
// shared adder bus of the J68 multiply/divide sequencer.
interface j68_muldiv_seq_if;
  logic        start;
  logic        op_div;
`ifdef J68_MULDIV_SIGNED_EN
  logic        op_signed;
`endif
  logic [31:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;
  logic        overflow;
  logic        as_add_sub;
  logic [31:0] as_dataa;
  logic [31:0] as_datab;
  logic [31:0] as_result;
  logic        as_cout;

`ifdef J68_MULDIV_SIGNED_EN
  modport master (
    output start, op_div, op_signed, opa, opb,
    output as_result, as_cout,
    input  busy, done, result, div_zero, overflow,
    input  as_add_sub, as_dataa, as_datab
  );
  modport slave (
    input  start, op_div, op_signed, opa, opb,
    input  as_result, as_cout,
    output busy, done, result, div_zero, overflow,
    output as_add_sub, as_dataa, as_datab
  );
`else
  modport master (
    output start, op_div, opa, opb,
    output as_result, as_cout,
    input  busy, done, result, div_zero, overflow,
    input  as_add_sub, as_dataa, as_datab
  );
  modport slave (
    input  start, op_div, opa, opb,
    input  as_result, as_cout,
    output busy, done, result, div_zero, overflow,
    output as_add_sub, as_dataa, as_datab
  );
`endif
endinterface

// File: rtl/j68_muldiv_seq.sv
// j68_muldiv_seq: MULU/DIVU sequencer over one shared 32-bit adder.
// Signed MULS/DIVS are added when J68_MULDIV_SIGNED_EN is defined.
module j68_muldiv_seq (
  input  logic            clk,
  input  logic            rst_n,
  j68_muldiv_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_CHECK, S_DIV, S_DONE, S_ABS, S_SGN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] a_q, acc_q, res_q;
  logic [15:0] b_q, rem_q, quo_q;
  logic        dz_q, ov_q;
  logic        zdiv, last;
  logic [16:0] div_s;
  logic [15:0] q_next, r_next;
  logic [31:0] mul_next, orig_a;
  logic        fin_sgn, sovf;
`ifdef J68_MULDIV_SIGNED_EN
  logic        sgn_q, div_q;
  logic        neg_a_q, neg_b_q, neg_q_q, neg_r_q;
  logic [31:0] orig_q;
`endif

  assign zdiv     = bus.op_div && (bus.opb == 16'd0);
  assign last     = (cnt_q == 4'd15);
  // dividend low half is consumed MSB first
  assign div_s    = {rem_q, a_q[~cnt_q]};
  assign q_next   = {quo_q[14:0], bus.as_cout};
  assign r_next   = bus.as_cout ? bus.as_result[15:0]
                                : div_s[15:0];
  assign mul_next = a_q[cnt_q] ? bus.as_result : acc_q;

`ifdef J68_MULDIV_SIGNED_EN
  assign orig_a  = orig_q;
  assign fin_sgn = neg_q_q | neg_r_q;
  assign sovf    = sgn_q & (neg_q_q ? (q_next > 16'h8000)
                                    : q_next[15]);
`else
  assign orig_a  = a_q;
  assign fin_sgn = 1'b0;
  assign sovf    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bus.start) begin
          if (zdiv)
            state_d = S_DONE;
`ifdef J68_MULDIV_SIGNED_EN
          else if (bus.op_signed)
            state_d = S_ABS;
`endif
          else if (bus.op_div)
            state_d = S_CHECK;
          else
            state_d = S_MUL;
        end
`ifdef J68_MULDIV_SIGNED_EN
      S_ABS:
        if (cnt_q[0])
          state_d = div_q ? S_CHECK : S_MUL;
      S_SGN:
        if (!(div_q && neg_q_q && neg_r_q))
          state_d = S_DONE;
`endif
      S_MUL:
        if (last)
          state_d = fin_sgn ? S_SGN : S_DONE;
      S_CHECK:
        state_d = bus.as_cout ? S_DONE : S_DIV;
      S_DIV:
        if (last)
          state_d = (!sovf && fin_sgn) ? S_SGN : S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.as_add_sub = 1'b1;
    bus.as_dataa   = '0;
    bus.as_datab   = '0;
    unique case (state_q)
      S_MUL: begin
        bus.as_dataa = acc_q;
        bus.as_datab = {16'b0, b_q} << cnt_q;
      end
      S_CHECK: begin
        bus.as_add_sub = 1'b0;
        bus.as_dataa   = {16'b0, a_q[31:16]};
        bus.as_datab   = {16'b0, b_q};
      end
      S_DIV: begin
        bus.as_add_sub = 1'b0;
        bus.as_dataa   = {15'b0, div_s};
        bus.as_datab   = {16'b0, b_q};
      end
`ifdef J68_MULDIV_SIGNED_EN
      S_ABS:
        if (!cnt_q[0] && neg_a_q) begin
          bus.as_add_sub = 1'b0;
          bus.as_datab   = div_q ? a_q
                                 : {{16{a_q[15]}}, a_q[15:0]};
        end else if (cnt_q[0] && neg_b_q) begin
          bus.as_add_sub = 1'b0;
          bus.as_datab   = {{16{b_q[15]}}, b_q};
        end
      S_SGN: begin
        bus.as_add_sub = 1'b0;
        if (!div_q)
          bus.as_datab = acc_q;
        else if (neg_q_q)
          bus.as_datab = {16'b0, quo_q};
        else
          bus.as_datab = {16'b0, rem_q};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef J68_MULDIV_SIGNED_EN
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      orig_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE:
          if (bus.start) begin
            a_q   <= bus.opa;
            b_q   <= bus.opb;
            acc_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dz_q  <= zdiv;
            ov_q  <= 1'b0;
            res_q <= zdiv ? bus.opa : '0;
`ifdef J68_MULDIV_SIGNED_EN
            sgn_q   <= bus.op_signed;
            div_q   <= bus.op_div;
            orig_q  <= bus.opa;
            neg_a_q <= bus.op_signed &
                       (bus.op_div ? bus.opa[31] : bus.opa[15]);
            neg_b_q <= bus.op_signed & bus.opb[15];
            neg_q_q <= bus.op_signed &
                       ((bus.op_div ? bus.opa[31] : bus.opa[15])
                        ^ bus.opb[15]);
            neg_r_q <= bus.op_signed & bus.op_div & bus.opa[31];
`endif
          end
`ifdef J68_MULDIV_SIGNED_EN
        S_ABS:
          if (!cnt_q[0] && neg_a_q)
            a_q <= bus.as_result;
          else if (cnt_q[0] && neg_b_q)
            b_q <= bus.as_result[15:0];
        S_SGN:
          if (!div_q) begin
            res_q <= bus.as_result;
          end else if (neg_q_q) begin
            quo_q   <= bus.as_result[15:0];
            neg_q_q <= 1'b0;
            res_q   <= {rem_q, bus.as_result[15:0]};
          end else begin
            rem_q   <= bus.as_result[15:0];
            neg_r_q <= 1'b0;
            res_q   <= {bus.as_result[15:0], quo_q};
          end
`endif
        S_MUL: begin
          acc_q <= mul_next;
          if (last)
            res_q <= mul_next;
        end
        S_CHECK: begin
          rem_q <= a_q[31:16];
          if (bus.as_cout) begin
            ov_q  <= 1'b1;
            res_q <= orig_a;
          end
        end
        S_DIV: begin
          rem_q <= r_next;
          quo_q <= q_next;
          if (last) begin
            if (sovf) begin
              ov_q  <= 1'b1;
              res_q <= orig_a;
            end else begin
              res_q <= {r_next, q_next};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = res_q;
  assign bus.div_zero = dz_q;
  assign bus.overflow = ov_q;
endmodule

// File: tb/tb_j68_muldiv_seq.sv
// tb_j68_muldiv_seq: randomized check of the MUL/DIV sequencer
// against an arithmetic reference, with a behavioural adder.
module tb_j68_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  j68_muldiv_seq_if bus ();

  j68_muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.as_result = bus.as_add_sub
                       ? bus.as_dataa + bus.as_datab
                       : bus.as_dataa - bus.as_datab;
  assign bus.as_cout   = !bus.as_add_sub
                       && (bus.as_dataa >= bus.as_datab);

  task automatic run_op(
    input  logic        d,
    input  logic [31:0] a,
    input  logic [15:0] b,
    input  bit          hold,
    output logic [31:0] res,
    output logic        dz,
    output logic        ov,
    output int          lat,
    output bit          sub_seen,
    output bit          as_used
  );
    int w;
    w = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.op_div = d;
    bus.opa    = a;
    bus.opb    = b;
    bus.start  = 1'b1;
    @(posedge clk);
    lat = 1;
    sub_seen = 1'b0;
    as_used = 1'b0;
    #1;
    if (hold) begin
      bus.opa    = $urandom;
      bus.opb    = 16'($urandom);
      bus.op_div = ~d;
    end else begin
      bus.start = 1'b0;
    end
    while (1) begin
      if (bus.as_add_sub !== 1'b1)
        sub_seen = 1'b1;
      if (bus.as_add_sub !== 1'b1 || bus.as_dataa !== 32'd0
          || bus.as_datab !== 32'd0)
        as_used = 1'b1;
      if (bus.done === 1'b1 || lat >= 60)
        break;
      @(posedge clk);
      lat++;
      #1;
    end
    res = bus.result;
    dz  = bus.div_zero;
    ov  = bus.overflow;
    if (hold) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero, bus.overflow,
         bus.as_add_sub} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00001",
               {bus.busy, bus.done, bus.div_zero,
                bus.overflow, bus.as_add_sub});
    end
    checks++;
    if (bus.result !== 32'd0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", bus.result);
    end
    checks++;
    if ({bus.as_dataa, bus.as_datab} !== 64'd0) begin
      errors++;
      $display("FAIL reset_as got %h/%h want 0/0",
               bus.as_dataa, bus.as_datab);
    end
  endtask

  task automatic test_mul();
    logic [31:0] a, r, exp;
    logic [15:0] b;
    logic        dz, ov;
    int          lat;
    bit          ss, au;
    for (int i = 0; i < 12; i++) begin
      a = (i == 0) ? 32'h1234 : (i == 1) ? 32'hFFFF : $urandom;
      b = (i == 0) ? 16'h5678 : (i == 1) ? 16'hFFFF
                                         : 16'($urandom);
      exp = (i == 0) ? 32'h06260060 : (i == 1) ? 32'hFFFE0001
          : {16'b0, a[15:0]} * {16'b0, b};
      run_op(1'b0, a, b, 1'b0, r, dz, ov, lat, ss, au);
      checks++;
      if (r !== exp) begin
        errors++;
        $display("FAIL mul_result %h*%h got %h want %h",
                 a[15:0], b, r, exp);
      end
      checks++;
      if ({dz, ov} !== 2'b00) begin
        errors++;
        $display("FAIL mul_flags got %b want 00", {dz, ov});
      end
      checks++;
      if (lat != 17) begin
        errors++;
        $display("FAIL mul_latency got %0d want 17", lat);
      end
      checks++;
      if (ss) begin
        errors++;
        $display("FAIL mul_add_mode got sub want add");
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] a, r, exp;
    logic [15:0] b;
    logic        dz, ov;
    int          lat;
    bit          ss, au;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        a = 32'h000186A0;
        b = 16'h0007;
      end else begin
        b = 16'($urandom_range(1, 65535));
        a = {16'($urandom_range(0, int'(b) - 1)),
             16'($urandom)};
      end
      exp = (i == 0) ? 32'h000537CD
          : {16'(a % {16'b0, b}), 16'(a / {16'b0, b})};
      run_op(1'b1, a, b, 1'b0, r, dz, ov, lat, ss, au);
      checks++;
      if (r !== exp) begin
        errors++;
        $display("FAIL div_result %h/%h got %h want %h",
                 a, b, r, exp);
      end
      checks++;
      if ({dz, ov} !== 2'b00) begin
        errors++;
        $display("FAIL div_flags got %b want 00", {dz, ov});
      end
      checks++;
      if (lat != 18) begin
        errors++;
        $display("FAIL div_latency got %0d want 18", lat);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a, r;
    logic [15:0] b;
    logic        dz, ov;
    int          lat;
    bit          ss, au;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        a = 32'h00100000;
        b = 16'h0010;
      end else begin
        b = 16'($urandom_range(1, 65535));
        a = {16'($urandom_range(int'(b), 65535)),
             16'($urandom)};
      end
      run_op(1'b1, a, b, 1'b0, r, dz, ov, lat, ss, au);
      checks++;
      if (r !== a) begin
        errors++;
        $display("FAIL ovf_result got %h want %h", r, a);
      end
      checks++;
      if ({dz, ov} !== 2'b01) begin
        errors++;
        $display("FAIL ovf_flags got %b want 01", {dz, ov});
      end
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL ovf_latency got %0d want 2", lat);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] a, r;
    logic        dz, ov;
    int          lat;
    bit          ss, au;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      run_op(1'b1, a, 16'd0, 1'b1, r, dz, ov, lat, ss, au);
      checks++;
      if (r !== a || {dz, ov} !== 2'b10) begin
        errors++;
        $display("FAIL dz_result got %h/%b want %h/10",
                 r, {dz, ov}, a);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL dz_latency got %0d want 1", lat);
      end
      checks++;
      if (au) begin
        errors++;
        $display("FAIL dz_adder_idle got active want idle");
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL dz_start_in_done got busy=%b want 0",
                 bus.busy);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, r, exp;
    logic [15:0] b;
    logic        dz, ov;
    int          lat;
    bit          ss, au;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = 16'($urandom_range(1, 65535));
      if (i[0]) begin
        a[31:16] = 16'($urandom_range(0, int'(b) - 1));
        exp = {16'(a % {16'b0, b}), 16'(a / {16'b0, b})};
      end else begin
        exp = {16'b0, a[15:0]} * {16'b0, b};
      end
      run_op(i[0], a, b, 1'b1, r, dz, ov, lat, ss, au);
      checks++;
      if (r !== exp || lat != (i[0] ? 18 : 17)) begin
        errors++;
        $display("FAIL busy_ignore got %h lat %0d want %h",
                 r, lat, exp);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL start_in_done got busy=%b want 0",
                 bus.busy);
      end
    end
  endtask

  task automatic test_result_hold();
    logic [31:0] a, r, exp;
    logic [15:0] b;
    logic        dz, ov;
    int          lat;
    bit          ss, au;
    a = $urandom;
    b = 16'($urandom);
    exp = {16'b0, a[15:0]} * {16'b0, b};
    run_op(1'b0, a, b, 1'b0, r, dz, ov, lat, ss, au);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== exp || bus.busy !== 1'b0
        || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL hold got %h b%b d%b want %h b0 d0",
               bus.result, bus.busy, bus.done, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic        dz, ov;
    int          lat;
    bit          ss, au;
    @(negedge clk);
    bus.op_div = 1'b1;
    bus.opa    = 32'h000186A0;
    bus.opb    = 16'h0007;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    checks++;
    if (bus.busy !== 1'b1 || bus.as_add_sub !== 1'b0) begin
      errors++;
      $display("FAIL mid_div got busy=%b add_sub=%b want 1/0",
               bus.busy, bus.as_add_sub);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero, bus.overflow,
         bus.as_add_sub} !== 5'b00001
        || bus.result !== 32'd0
        || {bus.as_dataa, bus.as_datab} !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset got ctl %b res %h want 00001 0",
               {bus.busy, bus.done, bus.div_zero,
                bus.overflow, bus.as_add_sub}, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 32'h000186A0, 16'h0007, 1'b0,
           r, dz, ov, lat, ss, au);
    checks++;
    if (r !== 32'h000537CD || lat != 18) begin
      errors++;
      $display("FAIL after_reset got %h lat %0d want 000537cd 18",
               r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, r, exp;
    logic [15:0] b;
    logic        d, dz, ov, edz, eov;
    int          lat, elat;
    bit          ss, au;
    for (int i = 0; i < 10; i++) begin
      d = 1'($urandom);
      a = $urandom;
      b = 16'($urandom_range(0, 3)) == 16'd0 ? 16'd0
                                             : 16'($urandom);
      edz = 1'b0;
      eov = 1'b0;
      if (!d) begin
        exp = {16'b0, a[15:0]} * {16'b0, b};
        elat = 17;
      end else if (b == 16'd0) begin
        exp = a;
        edz = 1'b1;
        elat = 1;
      end else if (a / {16'b0, b} > 32'h0000FFFF) begin
        exp = a;
        eov = 1'b1;
        elat = 2;
      end else begin
        exp = {16'(a % {16'b0, b}), 16'(a / {16'b0, b})};
        elat = 18;
      end
      run_op(d, a, b, 1'b0, r, dz, ov, lat, ss, au);
      checks++;
      if (r !== exp || {dz, ov} !== {edz, eov}
          || lat != elat) begin
        errors++;
        $display("FAIL b2b op%0d got %h %b %0d want %h %b %0d",
                 d, r, {dz, ov}, lat, exp, {edz, eov}, elat);
      end
    end
  endtask

`ifdef J68_MULDIV_SIGNED_EN
  task automatic test_signed();
    logic [31:0] r;
    logic        dz, ov;
    int          lat;
    bit          ss, au;
    bus.op_signed = 1'b1;
    run_op(1'b1, 32'hFFFE7960, 16'h0007, 1'b0,
           r, dz, ov, lat, ss, au);
    checks++;
    if (r !== 32'hFFFBC833 || {dz, ov} !== 2'b00
        || lat != 22) begin
      errors++;
      $display("FAIL sdiv got %h %b %0d want fffbc833 00 22",
               r, {dz, ov}, lat);
    end
    run_op(1'b0, 32'h0000FFFE, 16'h0003, 1'b0,
           r, dz, ov, lat, ss, au);
    checks++;
    if (r !== 32'hFFFFFFFA || lat != 20) begin
      errors++;
      $display("FAIL smul got %h %0d want fffffffa 20", r, lat);
    end
    bus.op_signed = 1'b0;
  endtask
`endif

  initial begin
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.opa    = '0;
    bus.opb    = '0;
`ifdef J68_MULDIV_SIGNED_EN
    bus.op_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_mul();
    test_div();
    test_overflow();
    test_div_zero();
    test_busy_ignore();
    test_result_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef J68_MULDIV_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
